drp_to_wb: RTL and testbench
============================

Name: drp_to_wb

Overview:
- DRP target (responder) that turns single DRP read/write transactions into Wishbone classic master cycles.
- Lets DRP-master logic, such as transceiver wizards or DRP arbiters, reach the Wishbone register space (ethernet, 32-bit data).
- Sits between one DRP port and one Wishbone target.
- One transaction in flight; DRP 16-bit data maps onto the low half of a 32-bit WB word.

Parameters:
- ADDR_WIDTH, 13, width of wb_adr_o (byte address); must be ≥ 12.
- BASE_ADDR, 0, value driven on wb_adr_o[ADDR_WIDTH-1:12]; the low 12 bits come from DRP.
- TIMEOUT_CYCLES, 255, WB cycles to wait for a termination before aborting (used only with DRP_TO_WB_TIMEOUT_EN).

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_ni  in  1  asynchronous, active-low reset
- drpen  in  1  DRP enable; one-cycle strobe starting a transaction
- drpwe  in  1  DRP write enable; qualified by drpen
- drpaddr  in  10  DRP word address
- drpdi  in  16  DRP write data
- drprdy  out  1  one-cycle completion pulse
- drpdo  out  16  read data; valid when drprdy=1
- wb_cyc_o, wb_stb_o  out  1 each  WB master cycle/strobe
- wb_we_o  out  1  WB write
- wb_adr_o  out  ADDR_WIDTH  {BASE_ADDR, drpaddr, 2'b00}
- wb_dat_o  out  32  {16'h0, drpdi}
- wb_sel_o  out  4  fixed 4'b0011
- wb_dat_i  in  32  WB read data; only [15:0] used
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  WB terminations
- overrun_o  out  1  sticky: drpen seen while busy
- bus_err_o  out  1  sticky: a transaction ended by err/rty/timeout
- status_clr_i  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0 (drpdo=16'h0, wb_adr_o=0, wb_dat_o=0, flags 0).
- Reset mid-transaction drops wb_cyc_o/wb_stb_o immediately; no drprdy is produced.
- FSM IDLE -> BUS -> RESP -> IDLE.
- IDLE:
  - drpen=1 registers drpwe, drpaddr and drpdi into wb_we_o, wb_adr_o and wb_dat_o.
  - Asserts wb_cyc_o and wb_stb_o on the next edge -> BUS.
- BUS:
  - cyc, stb and all address/data held stable until a termination.
  - wb_ack_i: capture drpdo <= wb_dat_i[15:0] on reads; drpdo <= 16'h0 on writes.
  - wb_err_i or wb_rty_i: drpdo <= 16'hFFFF and set bus_err_o. No retry is attempted.
  - Any termination drops cyc/stb on that edge -> RESP.
  - Priority when several terminations are high together: err > rty > ack.
- RESP:
  - drprdy=1 for exactly one cycle; drpdo valid in that cycle -> IDLE.
  - drpdo holds its value afterwards until the next capture.
- Latency: drpen at edge 0 -> stb visible after edge 0. Zero-wait ack in the first BUS cycle -> drprdy high after edge 2. Minimum DRP turnaround is 3 cycles.
- drpen in BUS or RESP violates the DRP protocol:
  - the request is ignored and overrun_o is set;
  - the in-flight transaction is unaffected.
- drpen in the same cycle as drprdy is also treated as overrun; the DRP master must wait one cycle after drprdy.
- status_clr_i: clears both flags. When a set event occurs in the same cycle, set wins.
- No combinational path from any input to any output.

Optional Feature:
- Macro DRP_TO_WB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter (sized by $clog2(TIMEOUT_CYCLES+1)) resets on entry to BUS and increments each BUS cycle.
  - When it reaches TIMEOUT_CYCLES with no termination: drop cyc/stb, drpdo <= 16'hDEAD, set bus_err_o, go to RESP.
  - A termination arriving in the same cycle as the timeout wins.
- Undefined: no counter; BUS waits indefinitely; TIMEOUT_CYCLES is ignored.

Decomposition:
- Shared package drp_pkg holds:
  - the state enum;
  - DRP_ADDR_W=10 and DRP_DATA_W=16;
  - the response constants DRP_ERR_DATA=16'hFFFF and DRP_TIMEOUT_DATA=16'hDEAD.
- The block is a single module. The timeout counter stays inline; no sub-module is needed.

Test Plan:
- Read: drpen, drpwe=0, drpaddr=10'h155. Expect wb_adr_o=13'h0554, wb_we_o=0, wb_sel_o=4'b0011. Ack after 3 wait cycles with wb_dat_i=32'hABCD1234 -> one drprdy pulse, drpdo=16'h1234.
- Write: drpaddr=10'h3FF, drpdi=16'hBEEF. Expect wb_dat_o=32'h0000BEEF, wb_we_o=1, wb_adr_o=13'h0FFC. Zero-wait ack -> drprdy exactly 2 edges after the drpen edge, drpdo=0.
- Error: wb_err_i and wb_ack_i asserted together -> drpdo=16'hFFFF, bus_err_o=1. status_clr_i -> bus_err_o=0.
- Overrun: drpen during BUS and again in the drprdy cycle -> overrun_o=1. Exactly one WB cycle and one drprdy occur; wb_adr_o unchanged.
- Reset mid-BUS: pull wb_rst_ni low -> cyc/stb low without waiting for a clock, drprdy never pulses. After release, a new read completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8): no termination -> cyc drops after 8 BUS cycles, drpdo=16'hDEAD, bus_err_o=1. Macro undefined: cyc stays high for more than 1000 cycles.

Source files
------------

// File: rtl/drp_pkg.sv
// drp_pkg: shared types and constants for the DRP-to-Wishbone bridge.
package drp_pkg;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
    localparam int DRP_ADDR_W = 10;
    localparam int DRP_DATA_W = 16;
    localparam logic [DRP_DATA_W-1:0] DRP_ERR_DATA     = 16'hFFFF;
    localparam logic [DRP_DATA_W-1:0] DRP_TIMEOUT_DATA = 16'hDEAD;
endpackage

// File: rtl/drp_to_wb_if.sv
// drp_to_wb_if: DRP port plus Wishbone master bus of the bridge; slave = bridge view, master = environment view.
interface drp_to_wb_if #(parameter int ADDR_WIDTH = 13);
    import drp_pkg::*;
    logic                  drpen, drpwe, drprdy;
    logic [DRP_ADDR_W-1:0] drpaddr;
    logic [DRP_DATA_W-1:0] drpdi, drpdo;
    logic                  wb_cyc_o, wb_stb_o, wb_we_o;
    logic                  wb_ack_i, wb_err_i, wb_rty_i;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [31:0]           wb_dat_o, wb_dat_i;
    logic [3:0]            wb_sel_o;
    modport slave (
        input  drpen, drpwe, drpaddr, drpdi, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        output drprdy, drpdo, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
    modport master (
        output drpen, drpwe, drpaddr, drpdi, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  drprdy, drpdo, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/drp_to_wb.sv
// drp_to_wb: DRP responder turning single DRP accesses into Wishbone classic master cycles.
// Define DRP_TO_WB_TIMEOUT_EN to abort a WB cycle after TIMEOUT_CYCLES without termination.
module drp_to_wb
    import drp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 13,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    drp_to_wb_if.slave bus,
    input  logic       status_clr_i,
    output logic       overrun_o,
    output logic       bus_err_o
);
    localparam logic [ADDR_WIDTH-1:0] BASE_HI = ADDR_WIDTH'(BASE_ADDR) << 12;

    state_e                state_q;
    logic                  we_q, cyc_q, drprdy_q, overrun_q, bus_err_q, overrun_d, bus_err_d;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [31:0]           dat_q;
    logic [DRP_DATA_W-1:0] drpdo_q;
    logic                  accept, fault, timeout, done, unused_dat;

    // drprdy_q still high means the master broke the one-cycle gap rule
    assign accept    = bus.drpen && state_q == IDLE && !drprdy_q;
    assign fault     = bus.wb_err_i || bus.wb_rty_i;
    assign done      = state_q == BUS && (fault || bus.wb_ack_i || timeout);
    assign overrun_d = (bus.drpen && !accept) || (overrun_q && !status_clr_i);
    assign bus_err_d = (done && (fault || !bus.wb_ack_i)) || (bus_err_q && !status_clr_i);
    assign unused_dat = ^bus.wb_dat_i[31:16];

`ifdef DRP_TO_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1) < 8 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            drprdy_q  <= 1'b0;
            overrun_q <= 1'b0;
            bus_err_q <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            drpdo_q   <= '0;
`ifdef DRP_TO_WB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            overrun_q <= overrun_d;
            bus_err_q <= bus_err_d;
            drprdy_q  <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    we_q    <= bus.drpwe;
                    adr_q   <= BASE_HI | ADDR_WIDTH'({bus.drpaddr, 2'b00});
                    dat_q   <= {16'h0, bus.drpdi};
                    cyc_q   <= 1'b1;
                    state_q <= BUS;
`ifdef DRP_TO_WB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                BUS: begin
`ifdef DRP_TO_WB_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
`endif
                    if (done) begin
                        cyc_q   <= 1'b0;
                        state_q <= RESP;
                        drpdo_q <= fault ? DRP_ERR_DATA :
                                   bus.wb_ack_i ? (we_q ? '0 : bus.wb_dat_i[15:0]) : DRP_TIMEOUT_DATA;
                    end
                end
                RESP: begin
                    drprdy_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.drprdy   = drprdy_q;
    assign bus.drpdo    = drpdo_q;
    assign bus.wb_cyc_o = cyc_q;
    assign bus.wb_stb_o = cyc_q;
    assign bus.wb_we_o  = we_q;
    assign bus.wb_adr_o = adr_q;
    assign bus.wb_dat_o = dat_q;
    assign bus.wb_sel_o = 4'b0011;
    assign overrun_o    = overrun_q;
    assign bus_err_o    = bus_err_q;
endmodule

// File: tb/tb_drp_to_wb.sv
// tb_drp_to_wb: randomized scoreboard bench for drp_to_wb; honours DRP_TO_WB_TIMEOUT_EN.
module tb_drp_to_wb;
    localparam int AW   = 13;
    localparam int BASE = 0;
`ifdef DRP_TO_WB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [31:0]   dat;
    } req_t;

    logic clk = 1'b0, rst_n = 1'b0, status_clr_i = 1'b0;
    logic overrun_o, bus_err_o;
    int   vectors = 0, miscompares = 0;

    req_t        req_q[$];
    logic [15:0] rsp_q[$];
    req_t        cur_req;
    logic        cyc_prev = 1'b0;
    logic        exp_err = 1'b0, exp_ovr = 1'b0;

    int          next_wait = 0;
    logic [2:0]  next_kind = 3'b001;
    logic [31:0] next_dat  = '0;
    logic        next_clr  = 1'b0;

    always #5 clk = ~clk;

    drp_to_wb_if #(.ADDR_WIDTH(AW)) bus ();

    drp_to_wb #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .bus         (bus.slave),
        .status_clr_i(status_clr_i),
        .overrun_o   (overrun_o),
        .bus_err_o   (bus_err_o)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kind bits are {rty, err, ack}; kind 0 means the target never answers
    function automatic logic [15:0] rsp_model(logic we, logic [2:0] kind, logic [31:0] d);
        if (kind == 3'b000) return 16'hDEAD;
        if (kind[2:1] != 2'b00) return 16'hFFFF;
        return we ? 16'h0000 : d[15:0];
    endfunction

    // Wishbone target model
    initial begin
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0; bus.wb_dat_i = '0;
        forever begin
            do begin @(posedge clk); #1; end while (!bus.wb_cyc_o);
            if (next_kind == 3'b000) begin
                do begin @(posedge clk); #1; end while (bus.wb_cyc_o);
            end else begin
                repeat (next_wait) begin bus.wb_dat_i = $urandom; @(posedge clk); #1; end
                bus.wb_dat_i = next_dat;
                {bus.wb_rty_i, bus.wb_err_i, bus.wb_ack_i} = next_kind;
                status_clr_i = next_clr;
                @(posedge clk); #1;
                {bus.wb_rty_i, bus.wb_err_i, bus.wb_ack_i} = 3'b000;
                status_clr_i = 1'b0;
                bus.wb_dat_i = $urandom;
            end
        end
    end

    // monitor: WB request fields and DRP responses against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) cyc_prev = 1'b0;
        else begin
            if (bus.wb_cyc_o && !cyc_prev) begin
                chk("wb_cycle_expected", req_q.size() != 0, 1'b1);
                if (req_q.size() != 0) cur_req = req_q.pop_front();
            end
            if (bus.wb_cyc_o) begin
                chk("wb_stb", bus.wb_stb_o, 1'b1);
                chk("wb_adr", bus.wb_adr_o, cur_req.adr);
                chk("wb_we", bus.wb_we_o, cur_req.we);
                chk("wb_dat", bus.wb_dat_o, cur_req.dat);
                chk("wb_sel", bus.wb_sel_o, 4'b0011);
            end
            if (bus.drprdy) begin
                chk("drprdy_expected", rsp_q.size() != 0, 1'b1);
                if (rsp_q.size() != 0) chk("drpdo", bus.drpdo, rsp_q.pop_front());
            end
            cyc_prev = bus.wb_cyc_o;
        end
    end

    task automatic do_txn(logic we, logic [9:0] a, logic [15:0] di, int w,
                          logic [2:0] kind, logic [31:0] d, logic clr, logic ovr);
        int          n = 0;
        logic        got = 1'b0;
        logic [15:0] exp_do = rsp_model(we, kind, d);
        next_wait = w; next_kind = kind; next_dat = d; next_clr = clr;
        req_q.push_back('{we: we, adr: AW'((BASE << 12) + int'(a) * 4), dat: {16'h0, di}});
        rsp_q.push_back(exp_do);
        bus.drpen = 1'b1; bus.drpwe = we; bus.drpaddr = a; bus.drpdi = di;
        @(posedge clk); #1;
        bus.drpen = ovr; bus.drpwe = $urandom; bus.drpaddr = $urandom; bus.drpdi = $urandom;
        while (!got && n < 2000) begin
            @(posedge clk); n++; #1;
            bus.drpen = 1'b0;
            got = bus.drprdy;
        end
        chk("drprdy_seen", got, 1'b1);
        chk("latency", n, w + 2);
        bus.drpen = ovr;
        @(posedge clk); #1;
        bus.drpen = 1'b0;
        chk("drprdy_one_cycle", bus.drprdy, 1'b0);
        chk("drpdo_hold", bus.drpdo, exp_do);
        exp_err = kind == 3'b000 || kind[2:1] != 2'b00 || (exp_err && !clr);
        exp_ovr = ovr || (exp_ovr && !clr);
        chk("bus_err_o", bus_err_o, exp_err);
        chk("overrun_o", overrun_o, exp_ovr);
    endtask

    task automatic clr_flags();
        status_clr_i = 1'b1;
        @(posedge clk); #1;
        status_clr_i = 1'b0;
        exp_err = 1'b0; exp_ovr = 1'b0;
        chk("bus_err_cleared", bus_err_o, 1'b0);
        chk("overrun_cleared", overrun_o, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        bus.drpen = 1'b0; bus.drpwe = 1'b0; bus.drpaddr = '0; bus.drpdi = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_cyc", bus.wb_cyc_o, 1'b0);
        chk("rst_stb", bus.wb_stb_o, 1'b0);
        chk("rst_drprdy", bus.drprdy, 1'b0);
        chk("rst_drpdo", bus.drpdo, 16'h0);
        chk("rst_adr", bus.wb_adr_o, '0);
        chk("rst_dat", bus.wb_dat_o, '0);
        chk("rst_we", bus.wb_we_o, 1'b0);
        chk("rst_flags", {overrun_o, bus_err_o}, 2'b00);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_cyc", bus.wb_cyc_o, 1'b0);

        do_txn(1'b0, 10'h155, 16'h0, 3, 3'b001, 32'hABCD1234, 1'b0, 1'b0);
        do_txn(1'b1, 10'h3FF, 16'hBEEF, 0, 3'b001, $urandom, 1'b0, 1'b0);
        do_txn(1'b0, 10'h0F0, 16'h0, 1, 3'b011, 32'h5555AAAA, 1'b0, 1'b0);
        clr_flags();
        do_txn(1'b1, 10'h012, 16'h1357, 2, 3'b100, $urandom, 1'b0, 1'b0);
        clr_flags();
        do_txn(1'b0, 10'h201, 16'h0, 0, 3'b010, $urandom, 1'b1, 1'b0);
        do_txn(1'b0, 10'h0AA, 16'h0, 2, 3'b001, 32'h00007777, 1'b0, 1'b1);
        clr_flags();

        for (int i = 0; i < 40; i++) begin
            logic [2:0] k = $urandom_range(0, 9) < 6 ? 3'b001 : 3'($urandom_range(2, 7));
            do_txn(1'($urandom), 10'($urandom), 16'($urandom), $urandom_range(0, 3),
                   k, $urandom, $urandom_range(0, 7) == 0, 1'b0);
            if ($urandom_range(0, 9) == 0) clr_flags();
        end

`ifdef DRP_TO_WB_TIMEOUT_EN
        do_txn(1'b0, 10'h0C3, 16'h0, TO - 1, 3'b000, $urandom, 1'b0, 1'b0);
        hold = 3;
`else
        hold = 1100;
`endif

        next_kind = 3'b000;
        req_q.push_back('{we: 1'b0, adr: AW'((BASE << 12) + 16'h2A4 * 4), dat: 32'h0});
        bus.drpen = 1'b1; bus.drpwe = 1'b0; bus.drpaddr = 10'h2A4; bus.drpdi = 16'h0;
        @(posedge clk); #1;
        bus.drpen = 1'b0;
        repeat (hold) @(posedge clk);
        #1 chk("cyc_held_waiting", bus.wb_cyc_o, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_cyc", bus.wb_cyc_o, 1'b0);
        chk("rst_async_stb", bus.wb_stb_o, 1'b0);
        req_q.delete(); rsp_q.delete();
        exp_err = 1'b0; exp_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("no_drprdy_after_rst", bus.drprdy, 1'b0);
        do_txn(1'b0, 10'h111, 16'h0, 1, 3'b001, 32'h0000C0DE, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
